round_sequencer: RTL and testbench

Match-level controller for the Pong game datapath. It sits between the game logic, which reports goals, and the ball/paddle objects, which it holds, serves and releases. It keeps both players' scores, schedules the serve delay after each point, chooses the serve direction, and declares the winner. It is clocked from the 12 MHz system clock and advances its timers only on game ticks.

---
 rtl/round_sequencer.sv | 149 ++++++++++++++
 tb/tb_round_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Match-level controller for Pong: keeps both scores, times the serve after each
// point, picks the serve direction and declares the winner.
module round_sequencer #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       run,
    input  logic       new_match,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [3:0] score_one,
    output logic [3:0] score_two,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic       serve_pulse,
    output logic       match_over,
    output logic       winner
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] WIN   = 4'(WIN_SCORE);
    // A zero delay would never expire through a decrement, so treat it as one tick.
    localparam logic [7:0] DELAY = (SERVE_DELAY < 1) ? 8'd1 : 8'(SERVE_DELAY);

    state_t     state_reg, state_next;
    logic [7:0] timer_reg, timer_next;
    logic [3:0] score_one_reg, score_one_next;
    logic [3:0] score_two_reg, score_two_next;
    logic       serve_dir_reg, serve_dir_next;
    logic       serve_pulse_reg, serve_pulse_next;
    logic       match_over_reg, match_over_next;
    logic       winner_reg, winner_next;
    logic       goal_left_reg, goal_right_reg;

    logic       edge_left, edge_right;
    logic [3:0] score_one_inc, score_two_inc;

    assign edge_left     = goal_left & ~goal_left_reg;
    assign edge_right    = goal_right & ~goal_right_reg;
    assign score_one_inc = score_one_reg + 4'd1;
    assign score_two_inc = score_two_reg + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            timer_reg       <= 8'd0;
            score_one_reg   <= 4'd0;
            score_two_reg   <= 4'd0;
            serve_dir_reg   <= 1'b0;
            serve_pulse_reg <= 1'b0;
            match_over_reg  <= 1'b0;
            winner_reg      <= 1'b0;
            goal_left_reg   <= 1'b0;
            goal_right_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            score_one_reg   <= score_one_next;
            score_two_reg   <= score_two_next;
            serve_dir_reg   <= serve_dir_next;
            serve_pulse_reg <= serve_pulse_next;
            match_over_reg  <= match_over_next;
            winner_reg      <= winner_next;
            goal_left_reg   <= goal_left;
            goal_right_reg  <= goal_right;
        end
    end

    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        score_one_next   = score_one_reg;
        score_two_next   = score_two_reg;
        serve_dir_next   = serve_dir_reg;
        serve_pulse_next = 1'b0;
        match_over_next  = match_over_reg;
        winner_next      = winner_reg;

        if (new_match) begin
            state_next      = SERVE_WAIT;
            timer_next      = DELAY;
            score_one_next  = 4'd0;
            score_two_next  = 4'd0;
            serve_dir_next  = 1'b0;
            match_over_next = 1'b0;
            winner_next     = 1'b0;
        end else begin
            case (state_reg)
                SERVE_WAIT: begin
                    if (tick && run) begin
                        // Launch pulse is registered on the expiring tick so it
                        // lines up with the first PLAY cycle.
                        if (timer_reg <= 8'd1) begin
                            timer_next       = 8'd0;
                            state_next       = PLAY;
                            serve_pulse_next = 1'b1;
                        end else begin
                            timer_next = timer_reg - 8'd1;
                        end
                    end
                end
                PLAY: begin
                    if (run && (edge_left || edge_right)) begin
                        state_next = SERVE_WAIT;
                        timer_next = DELAY;
                        if (edge_left && !edge_right) begin
                            score_two_next = score_two_inc;
                            serve_dir_next = 1'b0;
                            if (score_two_inc == WIN) begin
                                state_next      = GAME_OVER;
                                match_over_next = 1'b1;
                                winner_next     = 1'b1;
                            end
                        end else if (edge_right && !edge_left) begin
                            score_one_next = score_one_inc;
                            serve_dir_next = 1'b1;
                            if (score_one_inc == WIN) begin
                                state_next      = GAME_OVER;
                                match_over_next = 1'b1;
                                winner_next     = 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ball_hold   = (state_reg != PLAY);
        score_one   = score_one_reg;
        score_two   = score_two_reg;
        serve_dir   = serve_dir_reg;
        serve_pulse = serve_pulse_reg;
        match_over  = match_over_reg;
        winner      = winner_reg;
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Table-driven bench for round_sequencer (WIN_SCORE=2, SERVE_DELAY=3) with a
// scoreboard queue of expected outputs and hand-written async-reset checks.
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, run, new_match, goal_left, goal_right;
    logic [3:0] score_one, score_two;
    logic       ball_hold, serve_dir, serve_pulse, match_over, winner;

    round_sequencer #(.WIN_SCORE(2), .SERVE_DELAY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .run        (run),
        .new_match  (new_match),
        .goal_left  (goal_left),
        .goal_right (goal_right),
        .score_one  (score_one),
        .score_two  (score_two),
        .ball_hold  (ball_hold),
        .serve_dir  (serve_dir),
        .serve_pulse(serve_pulse),
        .match_over (match_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic        rn;
        logic        nm;
        logic        gl;
        logic        gr;
        logic [12:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    function automatic logic [12:0] pack_exp(input int s1, input int s2, input logic hold,
                                             input logic dir, input logic pulse,
                                             input logic mo, input logic win);
        return {4'(s1), 4'(s2), hold, dir, pulse, mo, win};
    endfunction

    task automatic add(input logic tk, input logic rn, input logic nm, input logic gl,
                       input logic gr, input int s1, input int s2, input logic hold,
                       input logic dir, input logic pulse, input logic mo, input logic win);
        vec_t v;
        v.tk = tk; v.rn = rn; v.nm = nm; v.gl = gl; v.gr = gr;
        v.exp = pack_exp(s1, s2, hold, dir, pulse, mo, win);
        vecs.push_back(v);
    endtask

    function automatic logic [12:0] actual();
        return {score_one, score_two, ball_hold, serve_dir, serve_pulse, match_over, winner};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = actual();
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got s1=%0d s2=%0d hold=%b dir=%b pulse=%b mo=%b win=%b, want s1=%0d s2=%0d hold=%b dir=%b pulse=%b mo=%b win=%b",
                     name, act[12:9], act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[12:9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: s1=%0d s2=%0d hold=%b dir=%b pulse=%b mo=%b win=%b",
                     name, act[12:9], act[8:5], act[4], act[3], act[2], act[1], act[0]);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        tick = v.tk; run = v.rn; new_match = v.nm; goal_left = v.gl; goal_right = v.gr;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), sb.pop_front());
    endtask

    initial begin
        // ---- stimulus table: inputs tk rn nm gl gr, expected s1 s2 hold dir pulse mo win
        add(1,1,0,0,0, 0,0,1,0,0,0,0);                          // IDLE ignores ticks
        add(0,1,1,0,0, 0,0,1,0,0,0,0);                          // new_match -> SERVE_WAIT
        for (int t = 0; t < 3; t++) begin                       // tick every 4 clks
            for (int k = 0; k < 3; k++) add(0,1,0,0,0, 0,0,1,0,0,0,0);
            if (t < 2) add(1,1,0,0,0, 0,0,1,0,0,0,0);
            else       add(1,1,0,0,0, 0,0,0,0,1,0,0);           // serve after third tick
        end
        add(0,1,0,0,0, 0,0,0,0,0,0,0);                          // pulse lasts one clk
        add(0,1,0,0,1, 1,0,1,1,0,0,0);                          // goal_right edge scores
        for (int k = 0; k < 9; k++) add(0,1,0,0,1, 1,0,1,1,0,0,0);  // held level: once
        add(0,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,0,1,1,0,0);
        add(0,1,0,0,0, 1,0,0,1,0,0,0);
        add(0,1,0,1,1, 1,0,1,1,0,0,0);                          // simultaneous edges: replay
        add(0,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,1,1,0,0,0);                          // full delay again
        add(1,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,0,1,1,0,0);
        add(0,1,0,1,0, 1,1,1,0,0,0,0);                          // goal_left: p2 scores
        add(0,1,0,0,0, 1,1,1,0,0,0,0);
        add(1,1,0,0,0, 1,1,1,0,0,0,0);                          // one tick consumed
        for (int k = 0; k < 50; k++)                            // paused, edge injected
            add(1,0,0,(k == 20),0, 1,1,1,0,0,0,0);
        add(1,1,0,0,0, 1,1,1,0,0,0,0);
        add(1,1,0,0,0, 1,1,0,0,1,0,0);                          // only remaining 2 ticks
        add(0,1,0,0,0, 1,1,0,0,0,0,0);
        add(0,0,0,1,0, 1,1,0,0,0,0,0);                          // edge while paused in PLAY
        add(0,1,0,1,0, 1,1,0,0,0,0,0);                          // level, no new edge
        add(0,1,0,0,0, 1,1,0,0,0,0,0);
        add(0,1,0,1,0, 1,2,1,0,0,1,1);                          // p2 reaches WIN_SCORE
        add(0,1,0,0,0, 1,2,1,0,0,1,1);
        add(1,1,0,0,0, 1,2,1,0,0,1,1);
        add(1,1,0,0,1, 1,2,1,0,0,1,1);                          // frozen in GAME_OVER
        add(1,1,0,1,1, 1,2,1,0,0,1,1);
        add(0,1,1,0,0, 0,0,1,0,0,0,0);                          // new_match clears
        add(1,1,0,0,0, 0,0,1,0,0,0,0);
        add(1,1,0,0,0, 0,0,1,0,0,0,0);
        add(1,1,0,0,0, 0,0,0,0,1,0,0);
        add(0,1,0,0,1, 1,0,1,1,0,0,0);
        add(0,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,1,1,0,0,0);
        add(1,1,0,0,0, 1,0,0,1,1,0,0);
        add(0,1,0,0,1, 2,0,1,1,0,1,0);                          // p1 wins
        add(0,1,1,0,0, 0,0,1,0,0,0,0);                          // new_match in GAME_OVER
        add(1,1,0,0,0, 0,0,1,0,0,0,0);
        add(1,1,0,0,0, 0,0,1,0,0,0,0);
        add(1,1,0,0,0, 0,0,0,0,1,0,0);
        add(0,1,0,0,0, 0,0,0,0,0,0,0);                          // left in PLAY

        // ---- reset state
        reset = 1'b0;
        tick = 0; run = 0; new_match = 0; goal_left = 0; goal_right = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", pack_exp(0,0,1,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // ---- asynchronous reset between clock edges while in PLAY with scores set
        @(negedge clk);
        tick = 0; run = 1; new_match = 0; goal_left = 0; goal_right = 1;
        @(posedge clk);
        #1;
        check("pre_reset_score", pack_exp(1,0,1,1,0,0,0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tick = 1; goal_right = 0;
        end
        @(posedge clk);
        #1;
        check("pre_reset_play", pack_exp(1,0,0,1,1,0,0));
        @(negedge clk);
        tick = 0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", pack_exp(0,0,1,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vec_t v;
            v.tk = 1; v.rn = 1; v.nm = 0; v.gl = 0; v.gr = (k == 2);
            v.exp = pack_exp(0,0,1,0,0,0,0);
            apply(v, 1000 + k);                                 // stays in IDLE
        end
        begin
            vec_t v;
            v.tk = 0; v.rn = 1; v.nm = 1; v.gl = 0; v.gr = 0;
            v.exp = pack_exp(0,0,1,0,0,0,0);
            apply(v, 1004);
            v.tk = 1; v.nm = 0;
            apply(v, 1005);
            apply(v, 1006);
            v.exp = pack_exp(0,0,0,0,1,0,0);
            apply(v, 1007);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
